// File: rtl/lfsr_range.sv
// lfsr_range: Fibonacci-style LFSR that, on request, steps until it produces
// a value inside [MIN, MAX]. It either returns that value or reports that the
// step budget ran out.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous, active-high reset
//   req      - request one in-range sample (sampled in IDLE only)
//   load     - load seed_in into the LFSR (sampled in IDLE only, wins over req)
//   seed_in  - seed for load; zero is replaced by SEED
//   data_out - last accepted in-range sample
//   valid    - one-cycle pulse, data_out was just updated
//   busy     - high while searching
//   err      - one-cycle pulse, budget exhausted without a sample
//   lockup   - one-cycle pulse, all-zero state found and reseeded
module lfsr_range #(
    parameter int unsigned      WIDTH     = 14,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(14'h2221),
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
    parameter logic [WIDTH-1:0] MIN       = WIDTH'(250),
    parameter logic [WIDTH-1:0] MAX       = WIDTH'(16000),
    parameter int unsigned      MAX_TRIES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             busy,
    output logic             err,
    output logic             lockup
);

    localparam int unsigned      CNT_W     = $clog2(MAX_TRIES + 1);
    localparam logic [CNT_W-1:0] TRIES_LIM = CNT_W'(MAX_TRIES);

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [CNT_W-1:0]   tries_q, tries_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               lockup_q, lockup_d;

    logic [WIDTH-1:0]   step_c;
    logic               in_range_c;
    logic [CNT_W-1:0]   tries_inc_c;
    logic               budget_done_c;

    // Next LFSR value and its acceptance test
    assign step_c        = {sreg_q[WIDTH-2:0], ^(sreg_q & TAPS)};
    assign in_range_c    = (step_c >= MIN) && (step_c <= MAX);
    assign tries_inc_c   = tries_q + CNT_W'(1);
    assign budget_done_c = (tries_inc_c == TRIES_LIM);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sreg_q   <= SEED;
            tries_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            tries_q  <= tries_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            lockup_q <= lockup_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        tries_d  = tries_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        lockup_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    sreg_d = (seed_in == '0) ? SEED : seed_in;
                end else if (req) begin
                    tries_d = '0;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                tries_d = tries_inc_c;
                if (sreg_q == '0) begin
                    // All-zero is a dead state for an XOR LFSR: reseed, still costs a try
                    sreg_d   = SEED;
                    lockup_d = 1'b1;
                    if (budget_done_c) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    sreg_d = step_c;
                    if (in_range_c) begin
                        data_d  = step_c;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else if (budget_done_c) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_out = data_q;
    assign valid    = valid_q;
    assign err      = err_q;
    assign lockup   = lockup_q;
    assign busy     = (state_q == SEARCH);

endmodule

// File: tb/tb_lfsr_range.sv
// Testbench for lfsr_range: three instances (default, zero-tap lockup case,
// tiny-budget error case) checked by a queue scoreboard against a
// whole-request arithmetic model.
module tb_lfsr_range;

    localparam int unsigned W    = 14;
    localparam int unsigned NI   = 3;
    localparam logic [W-1:0] SEED = 14'd1;

    typedef struct {
        bit           is_err;
        logic [W-1:0] data;
        int unsigned  due;
        int unsigned  locks;
    } exp_t;

    logic           clk;
    logic           rst;
    logic [NI-1:0]  req_v;
    logic [NI-1:0]  load_v;
    logic [W-1:0]   seed_in;
    logic [W-1:0]   dout [NI];
    logic [NI-1:0]  valid_v;
    logic [NI-1:0]  busy_v;
    logic [NI-1:0]  err_v;
    logic [NI-1:0]  lock_v;

    // Model parameters per instance
    logic [W-1:0] p_taps [NI] = '{14'h2221, 14'h0000, 14'h2221};
    logic [W-1:0] p_min  [NI] = '{14'd250, 14'd16383, 14'd16383};
    logic [W-1:0] p_max  [NI] = '{14'd16000, 14'd16383, 14'd16383};
    int unsigned  p_mt   [NI] = '{1024, 20, 4};

    // Model state
    logic [W-1:0] m_sreg [NI];
    logic [W-1:0] m_data [NI];
    int unsigned  m_free [NI];
    exp_t         exp_q  [NI][$];
    int unsigned  lock_cnt [NI];

    int unsigned cyc = 0;
    int n_chk  = 0;
    int n_fail = 0;

    lfsr_range u_a (
        .clk(clk), .rst(rst), .req(req_v[0]), .load(load_v[0]), .seed_in(seed_in),
        .data_out(dout[0]), .valid(valid_v[0]), .busy(busy_v[0]), .err(err_v[0]), .lockup(lock_v[0])
    );

    lfsr_range #(.TAPS(14'h0000), .MIN(14'd16383), .MAX(14'd16383), .MAX_TRIES(20)) u_b (
        .clk(clk), .rst(rst), .req(req_v[1]), .load(load_v[1]), .seed_in(seed_in),
        .data_out(dout[1]), .valid(valid_v[1]), .busy(busy_v[1]), .err(err_v[1]), .lockup(lock_v[1])
    );

    lfsr_range #(.MIN(14'd16383), .MAX(14'd16383), .MAX_TRIES(4)) u_c (
        .clk(clk), .rst(rst), .req(req_v[2]), .load(load_v[2]), .seed_in(seed_in),
        .data_out(dout[2]), .valid(valid_v[2]), .busy(busy_v[2]), .err(err_v[2]), .lockup(lock_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endfunction

    // Whole-request prediction: walk the sequence arithmetically until a hit or the budget ends
    function automatic exp_t predict(int i, int unsigned c0);
        exp_t         e;
        logic [W-1:0] s;
        int unsigned  t;
        s = m_sreg[i];
        e.is_err = 1'b1;
        e.locks  = 0;
        t = 0;
        for (int k = 1; k <= int'(p_mt[i]); k++) begin
            t = k;
            if (s == 0) begin
                s = SEED;
                e.locks++;
            end else begin
                s = W'((int'(s) * 2 + ($countones(s & p_taps[i]) % 2)) % 16384);
                if (s >= p_min[i] && s <= p_max[i]) begin
                    e.is_err = 1'b0;
                    break;
                end
            end
        end
        m_sreg[i] = s;
        if (!e.is_err) m_data[i] = s;
        e.data = m_data[i];
        e.due  = c0 + 1 + t;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(NI); i++) begin
            m_sreg[i] = SEED;
            m_data[i] = '0;
            m_free[i] = 0;
            exp_q[i].delete();
        end
    endtask

    // Issue one command at a negedge; the model decides which instances accept it
    task automatic do_cmd(input logic [NI-1:0] rq, input logic [NI-1:0] ld, input logic [W-1:0] sd);
        exp_t e;
        for (int i = 0; i < int'(NI); i++) begin
            if (cyc >= m_free[i]) begin
                if (ld[i]) begin
                    m_sreg[i] = (sd == 0) ? SEED : sd;
                end else if (rq[i]) begin
                    e = predict(i, cyc);
                    exp_q[i].push_back(e);
                    m_free[i] = e.due;
                end
            end
        end
        req_v   = rq;
        load_v  = ld;
        seed_in = sd;
        @(posedge clk);
        @(negedge clk);
        req_v  = '0;
        load_v = '0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            done = 1'b1;
            for (int i = 0; i < int'(NI); i++)
                if (cyc < m_free[i] || busy_v[i] || exp_q[i].size() != 0) done = 1'b0;
            if (!done) @(negedge clk);
        end
        chk("idle_within_budget", 32'(done), 32'd1);
    endtask

    // Monitor: pops the scoreboard whenever an instance reports valid or err
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NI); i++) lock_cnt[i] = 0;
        end else begin
            for (int i = 0; i < int'(NI); i++) begin
                exp_t e;
                if (lock_v[i]) lock_cnt[i]++;
                if (valid_v[i] || err_v[i]) begin
                    chk("valid_err_exclusive", 32'(valid_v[i] & err_v[i]), 32'd0);
                    chk("response_expected", 32'(exp_q[i].size() > 0), 32'd1);
                    if (exp_q[i].size() > 0) begin
                        e = exp_q[i].pop_front();
                        chk("resp_is_err", 32'(err_v[i]), 32'(e.is_err));
                        chk("resp_data", 32'(dout[i]), 32'(e.data));
                        chk("resp_cycle", cyc, e.due);
                        chk("resp_lockups", lock_cnt[i], e.locks);
                    end
                    lock_cnt[i] = 0;
                end
            end
        end
    end

    initial begin
        logic [NI-1:0] rq, ld;
        logic [W-1:0]  sd;
        rst     = 1'b1;
        req_v   = '0;
        load_v  = '0;
        seed_in = '0;
        model_reset();
        #3;
        for (int i = 0; i < int'(NI); i++) begin
            chk("reset_data_out", 32'(dout[i]), 32'd0);
            chk("reset_busy", 32'(busy_v[i]), 32'd0);
            chk("reset_pulses", 32'({valid_v[i], err_v[i], lock_v[i]}), 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Default request from reset seed: 7 steps to 253
        do_cmd(3'b001, 3'b000, '0);
        chk("busy_after_req", 32'(busy_v[0]), 32'd1);
        wait_idle();
        chk("first_sample_253", 32'(dout[0]), 32'd253);

        // Zero seed load falls back to SEED; same answer, no lockup
        do_cmd(3'b000, 3'b001, 14'd0);
        chk("load_keeps_idle", 32'(busy_v[0]), 32'd0);
        do_cmd(3'b001, 3'b000, '0);
        wait_idle();
        chk("zero_seed_sample_253", 32'(dout[0]), 32'd253);

        // Tiny budget on instance C: error after 4 edges, data stays 0
        do_cmd(3'b100, 3'b000, '0);
        wait_idle();
        chk("budget_err_data_zero", 32'(dout[2]), 32'd0);

        // Zero taps on instance B: shifts to zero, one lockup, then budget error
        do_cmd(3'b000, 3'b010, 14'd2);
        do_cmd(3'b010, 3'b000, '0);
        wait_idle();

        // req+load together: load wins; then a 1-step request from 253
        do_cmd(3'b001, 3'b001, 14'd253);
        chk("req_load_stays_idle", 32'(busy_v[0]), 32'd0);
        do_cmd(3'b001, 3'b000, '0);
        wait_idle();

        // req during SEARCH is dropped
        do_cmd(3'b000, 3'b001, 14'd1);
        do_cmd(3'b001, 3'b000, '0);
        do_cmd(3'b001, 3'b000, '0);
        do_cmd(3'b001, 3'b001, 14'd77);
        wait_idle();

        // Reset on the 3rd search edge aborts the request
        do_cmd(3'b000, 3'b001, 14'd1);
        do_cmd(3'b001, 3'b000, '0);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        #1;
        chk("rst_busy_low", 32'(busy_v[0]), 32'd0);
        chk("rst_data_zero", 32'(dout[0]), 32'd0);
        chk("rst_valid_low", 32'(valid_v[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_cmd(3'b001, 3'b000, '0);
        wait_idle();
        chk("post_rst_sample_253", 32'(dout[0]), 32'd253);

        // Randomized traffic, including overlapping requests and loads
        for (int n = 0; n < 80; n++) begin
            rq = NI'($urandom_range(0, 7));
            ld = NI'($urandom_range(0, 7)) & NI'($urandom_range(0, 7));
            sd = ($urandom_range(0, 3) == 0) ? 14'd0 : W'($urandom);
            do_cmd(rq, ld, sd);
            repeat ($urandom_range(0, 12)) @(negedge clk);
            if ($urandom_range(0, 5) == 0) wait_idle();
        end
        wait_idle();

        for (int i = 0; i < int'(NI); i++)
            chk("scoreboard_drained", exp_q[i].size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_range.md
LFSR_RANGE -- requirements
Module: lfsr_range

Interface
REQ-001 The block SHALL have these parameters:
- WIDTH, 14: LFSR and data width, 3..32.
- TAPS, 14'h2221: feedback mask; bit i set means sreg[i] feeds XOR (default = stages 1,6,10,14).
- SEED, 1: power-up, reset and substitute seed; nonzero.
- MIN, 250: inclusive lower bound of accepted samples.
- MAX, 16000: inclusive upper bound; MIN <= MAX < 2^WIDTH.
- MAX_TRIES, 1024: step budget per request, >= 1.
REQ-002 The block SHALL have these ports (clock and reset first):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  request one in-range sample; sampled only in IDLE.
- load  in  1  load seed_in into LFSR; sampled only in IDLE.
- seed_in  in  WIDTH  seed value for load.
- data_out  out  WIDTH  last accepted in-range sample.
- valid  out  1  one-cycle pulse: data_out updated.
- busy  out  1  high while in SEARCH.
- err  out  1  one-cycle pulse: budget exhausted, no sample.
- lockup  out  1  one-cycle pulse: all-zero state detected and reseeded.
REQ-003 There SHALL be one clock domain; reset is asynchronous and active-high, all other inputs synchronous to clk.

Function
REQ-004 The LFSR next state SHALL be {sreg[WIDTH-2:0], fb}, where fb = XOR-reduce(sreg & TAPS).
REQ-005 The FSM SHALL have two states: IDLE and SEARCH; busy = (state == SEARCH).
REQ-006 In IDLE, load=1 SHALL set sreg to seed_in, or to SEED if seed_in == 0, with no other output change.
REQ-007 In IDLE, req=1 with load=0 SHALL clear the try counter and enter SEARCH. If req and load are both high, load SHALL win and req SHALL be ignored.
REQ-008 In SEARCH, every edge SHALL advance sreg to next state and increment the try counter.
REQ-009 If the next state satisfies MIN <= next <= MAX (unsigned compare), the same edge SHALL:
- latch it into data_out;
- pulse valid for the following cycle;
- return to IDLE.
REQ-010 If the next state is out of range and the try count reaches MAX_TRIES on that edge, the block SHALL pulse err for one cycle, return to IDLE and leave data_out unchanged.
REQ-011 If sreg == 0 in SEARCH, the edge SHALL load SEED instead of stepping, pulse lockup, and count that edge as a try.
REQ-012 req and load asserted during SEARCH SHALL be ignored, not queued.
REQ-013 Samples out of range SHALL be rejected (redrawn), never clamped.
REQ-014 valid and err SHALL never be high in the same cycle.
REQ-015 Latency: the number of SEARCH edges equals the number of steps to the first in-range value. The minimum is 1, so valid is high at the earliest 2 cycles after req is sampled.
REQ-016 The try counter SHALL be clog2(MAX_TRIES+1) bits wide and SHALL not wrap within one request.
REQ-017 The block SHALL contain no free-running stepping: sreg changes only on load, SEARCH steps or reset.

Reset
REQ-018 rst=1 SHALL immediately, regardless of clk, set:
- sreg = SEED, data_out = 0, state = IDLE;
- try counter = 0;
- valid = err = lockup = 0.
REQ-019 rst asserted mid-SEARCH SHALL abort the request with no valid or err pulse; operation resumes on the first edge after deassertion.

Verification
REQ-020 Default parameters, reset, then a req pulse -> SEARCH for 7 edges with sreg 3, 7, 15, 31, 63, 126, 253; then valid=1 for one cycle, data_out=253, busy falls.
REQ-021 load with seed_in=0, then req -> sreg starts from 1 and the response is identical to REQ-020; lockup never asserted.
REQ-022 MIN=MAX=16383, MAX_TRIES=4, req -> after 4 edges err=1 for one cycle, valid=0, data_out=0.
REQ-023 TAPS=0, seed 2, req -> sreg shifts to 4, 8, ... then 0; on the next edge lockup=1 and sreg=SEED; err=1 once MAX_TRIES is reached.
REQ-024 Assert rst on the 3rd SEARCH edge of the REQ-020 request -> busy=0, data_out=0, sreg=1 immediately; a fresh req reproduces REQ-020 exactly.
REQ-025 req and load high together in IDLE with seed_in=253 -> sreg=253, state stays IDLE, no valid; req during SEARCH has no effect.
